wb_redirect_ctrl: RTL and testbench

//  Sequences pipeline recovery after a write-back branch resolution. Accepts the WB-stage

---
 rtl/wb_redirect_ctrl.sv | 105 ++++++++++
 tb/tb_wb_redirect_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_redirect_ctrl.sv
// rtl/wb_redirect_ctrl.sv - write-back redirect, fetch drain and predictor update sequencer
module wb_redirect_ctrl #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DRAIN_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 control_flush,
  input  logic [WIDTH-1:0]     new_pc,
  input  logic [WIDTH-1:0]     branch_pc,
  input  logic                 branch_taken,
  input  logic                 pipe_stall,
  input  logic                 imem_inflight,
  input  logic                 imem_resp,
  output logic                 flush_pipe,
  output logic                 pc_load,
  output logic [WIDTH-1:0]     pc_redirect,
  output logic                 fetch_hold,
  output logic                 fetch_squash,
  output logic                 upd_valid,
  output logic [WIDTH-1:0]     upd_pc,
  output logic [WIDTH-1:0]     upd_target,
  output logic                 upd_taken,
  input  logic                 upd_ready,
  output logic                 upd_dropped,
  output logic                 drain_timeout,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

  logic [0:0] state;
  logic [7:0] drain_cnt;
  logic       accept;
  logic       upd_take;

  // Gated by reset_n so the Mealy outputs are also 0 while reset is held.
  assign accept   = control_flush & ~pipe_stall & reset_n;
  assign upd_take = upd_valid & upd_ready;

  always_comb begin
    flush_pipe   = accept;
    pc_load      = accept;
    pc_redirect  = accept ? new_pc : '0;
    fetch_hold   = (state == DRAIN);
    fetch_squash = imem_resp & (accept | (state == DRAIN));
  end

  // A response arriving in DRAIN always ends the drain, even alongside a new accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      drain_cnt     <= 8'd0;
      drain_timeout <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && imem_inflight && !imem_resp) begin
        state     <= DRAIN;
        drain_cnt <= 8'd0;
      end
    end else begin
      if (imem_resp) begin
        state <= IDLE;
      end else if (accept) begin
        drain_cnt <= 8'd0;
      end else if (drain_cnt == DRAIN_LAST) begin
        state         <= IDLE;
        drain_timeout <= 1'b1;
      end else begin
        drain_cnt <= drain_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_target  <= '0;
      upd_taken   <= 1'b0;
      upd_dropped <= 1'b0;
    end else if (accept) begin
      if (upd_valid && !upd_ready) begin
        upd_dropped <= 1'b1;
      end
      upd_valid  <= 1'b1;
      upd_pc     <= branch_pc;
      upd_target <= new_pc;
      upd_taken  <= branch_taken;
    end else if (upd_take) begin
      upd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_count <= '0;
    end else if (accept) begin
      flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wb_redirect_ctrl.sv
// tb/tb_wb_redirect_ctrl.sv - randomized and directed bench for wb_redirect_ctrl
module tb_wb_redirect_ctrl;

  localparam int W    = 16;
  localparam int CW   = 16;
  localparam int DMAX = 15;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          control_flush;
  logic [W-1:0]  new_pc;
  logic [W-1:0]  branch_pc;
  logic          branch_taken;
  logic          pipe_stall;
  logic          imem_inflight;
  logic          imem_resp;
  logic          flush_pipe;
  logic          pc_load;
  logic [W-1:0]  pc_redirect;
  logic          fetch_hold;
  logic          fetch_squash;
  logic          upd_valid;
  logic [W-1:0]  upd_pc;
  logic [W-1:0]  upd_target;
  logic          upd_taken;
  logic          upd_ready;
  logic          upd_dropped;
  logic          drain_timeout;
  logic [CW-1:0] flush_count;

  always #5 clk = ~clk;

  wb_redirect_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .reset_n(reset_n), .control_flush(control_flush), .new_pc(new_pc),
    .branch_pc(branch_pc), .branch_taken(branch_taken), .pipe_stall(pipe_stall),
    .imem_inflight(imem_inflight), .imem_resp(imem_resp), .flush_pipe(flush_pipe),
    .pc_load(pc_load), .pc_redirect(pc_redirect), .fetch_hold(fetch_hold),
    .fetch_squash(fetch_squash), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .upd_dropped(upd_dropped), .drain_timeout(drain_timeout), .flush_count(flush_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: drain tracked as cycles remaining, update as a single pending slot.
  bit          m_drain;
  int          m_left;
  bit          m_uv;
  logic [15:0] m_upc;
  logic [15:0] m_utgt;
  bit          m_utk;
  bit          m_drop;
  bit          m_tmo;
  int          m_cnt;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_drain = 0; m_left = 0; m_uv = 0; m_upc = '0; m_utgt = '0;
    m_utk = 0; m_drop = 0; m_tmo = 0; m_cnt = 0;
  endtask

  task automatic check_all_zero(input string pfx);
    expect_eq({pfx, "_flush_pipe"}, {31'd0, flush_pipe}, 32'd0);
    expect_eq({pfx, "_pc_load"}, {31'd0, pc_load}, 32'd0);
    expect_eq({pfx, "_pc_redirect"}, {16'd0, pc_redirect}, 32'd0);
    expect_eq({pfx, "_fetch_hold"}, {31'd0, fetch_hold}, 32'd0);
    expect_eq({pfx, "_fetch_squash"}, {31'd0, fetch_squash}, 32'd0);
    expect_eq({pfx, "_upd_valid"}, {31'd0, upd_valid}, 32'd0);
    expect_eq({pfx, "_upd_pc"}, {16'd0, upd_pc}, 32'd0);
    expect_eq({pfx, "_upd_target"}, {16'd0, upd_target}, 32'd0);
    expect_eq({pfx, "_upd_taken"}, {31'd0, upd_taken}, 32'd0);
    expect_eq({pfx, "_upd_dropped"}, {31'd0, upd_dropped}, 32'd0);
    expect_eq({pfx, "_drain_timeout"}, {31'd0, drain_timeout}, 32'd0);
    expect_eq({pfx, "_flush_count"}, {16'd0, flush_count}, 32'd0);
  endtask

  task automatic drive_idle();
    control_flush = 0; new_pc = '0; branch_pc = '0; branch_taken = 0;
    pipe_stall = 0; imem_inflight = 0; imem_resp = 0; upd_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset_n = 0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  // One cycle: drive at negedge, check against the model, then advance the model.
  task automatic step(input logic cf, input logic [15:0] npc, input logic [15:0] bpc,
                      input logic bt, input logic st, input logic inf, input logic rsp,
                      input logic rdy);
    logic acc;
    @(negedge clk);
    control_flush = cf; new_pc = npc; branch_pc = bpc; branch_taken = bt;
    pipe_stall = st; imem_inflight = inf; imem_resp = rsp; upd_ready = rdy;
    #1;
    acc = cf & ~st;
    expect_eq("flush_pipe", {31'd0, flush_pipe}, {31'd0, acc});
    expect_eq("pc_load", {31'd0, pc_load}, {31'd0, acc});
    expect_eq("pc_redirect", {16'd0, pc_redirect}, {16'd0, acc ? npc : 16'd0});
    expect_eq("fetch_hold", {31'd0, fetch_hold}, {31'd0, m_drain});
    expect_eq("fetch_squash", {31'd0, fetch_squash}, {31'd0, rsp & (acc | m_drain)});
    expect_eq("upd_valid", {31'd0, upd_valid}, {31'd0, m_uv});
    expect_eq("upd_pc", {16'd0, upd_pc}, {16'd0, m_upc});
    expect_eq("upd_target", {16'd0, upd_target}, {16'd0, m_utgt});
    expect_eq("upd_taken", {31'd0, upd_taken}, {31'd0, m_utk});
    expect_eq("upd_dropped", {31'd0, upd_dropped}, {31'd0, m_drop});
    expect_eq("drain_timeout", {31'd0, drain_timeout}, {31'd0, m_tmo});
    expect_eq("flush_count", {16'd0, flush_count}, m_cnt);
    if (acc) begin
      if (m_uv && !rdy) m_drop = 1;
      m_uv = 1; m_upc = bpc; m_utgt = npc; m_utk = bt;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (m_uv && rdy) begin
      m_uv = 0;
    end
    if (m_drain) begin
      if (rsp) m_drain = 0;
      else if (acc) m_left = DMAX;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_drain = 0;
          m_tmo = 1;
        end
      end
    end else if (acc && inf && !rsp) begin
      m_drain = 1;
      m_left = DMAX;
    end
  endtask

  initial begin
    drive_idle();
    reset_n = 0;
    model_reset();
    #12;
    check_all_zero("por");
    @(negedge clk);
    reset_n = 1;

    // 1: simple redirect without inflight fetch
    step(1, 16'h3000, 16'h1234, 1, 0, 0, 0, 0);
    expect_eq("t1_redirect", {16'd0, pc_redirect}, 32'h3000);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_eq("t1_upd_target", {16'd0, upd_target}, 32'h3000);
    expect_eq("t1_count", {16'd0, flush_count}, 32'd1);

    // 2: drain until response at +3
    do_reset();
    step(1, 16'h4000, 16'h0010, 0, 0, 1, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 1, 0, 1);
    expect_eq("t2_hold1", {31'd0, fetch_hold}, 32'd1);
    step(0, 16'h0, 16'h0, 0, 0, 1, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 1, 1, 1);
    expect_eq("t2_squash3", {31'd0, fetch_squash}, 32'd1);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 1);
    expect_eq("t2_hold4", {31'd0, fetch_hold}, 32'd0);

    // 3: flush held off by stall
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 16'h5000, 16'h0020, 1, 1, 0, 0, 0);
    step(1, 16'h5000, 16'h0020, 1, 0, 0, 0, 0);
    expect_eq("t3_accept", {31'd0, flush_pipe}, 32'd1);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_eq("t3_count", {16'd0, flush_count}, 32'd1);

    // 4: overwrite of unconsumed update
    do_reset();
    step(1, 16'h0100, 16'h0030, 1, 0, 0, 0, 0);
    step(1, 16'h0200, 16'h0040, 0, 0, 0, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_eq("t4_target", {16'd0, upd_target}, 32'h0200);
    expect_eq("t4_dropped", {31'd0, upd_dropped}, 32'd1);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 0, 0, 0);
    expect_eq("t4_valid_off", {31'd0, upd_valid}, 32'd0);

    // 5: drain timeout
    do_reset();
    step(1, 16'h6000, 16'h0050, 1, 0, 1, 0, 1);
    for (int i = 0; i < DMAX; i++) step(0, 16'h0, 16'h0, 0, 0, 1, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 1, 0, 1);
    expect_eq("t5_timeout", {31'd0, drain_timeout}, 32'd1);
    expect_eq("t5_hold", {31'd0, fetch_hold}, 32'd0);

    // 6: async reset mid-drain with pending update
    do_reset();
    step(1, 16'h7000, 16'h0060, 1, 0, 1, 0, 0);
    step(0, 16'h0, 16'h0, 0, 0, 1, 0, 0);
    expect_eq("t6_pre_hold", {31'd0, fetch_hold}, 32'd1);
    #2;
    control_flush = 1; new_pc = 16'hBEEF;
    reset_n = 0;
    #1;
    check_all_zero("t6");
    model_reset();
    @(negedge clk);
    drive_idle();
    reset_n = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
